// File: rtl/i2c_regmap_slave_if.sv
// Pin-level bundle for the I2C register-map target: bus pins plus the board-side I/O it serves.
interface i2c_regmap_slave_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic       sda_oe;
    logic [7:0] led_out;
    logic [7:0] sw_in;
    logic       spi_active;
    logic [7:0] spi_rx_byte;

    modport slave (
        input  scl_i, sda_i, sw_in, spi_active, spi_rx_byte,
        output sda_o, sda_oe, led_out
    );

    modport master (
        output scl_i, sda_i, sw_in, spi_active, spi_rx_byte,
        input  sda_o, sda_oe, led_out
    );
endinterface

// File: rtl/i2c_regmap_slave.sv
// 7-bit I2C target with an integrated 8-bit register map (LEDs, switches, SPI status).
// Define I2C_AUTOINC_EN to auto-increment the register pointer after each data byte.
module i2c_regmap_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter logic [7:0] DEVICE_ID   = 8'hA7,
    parameter logic [7:0] VERSION_MAJ = 8'h01,
    parameter logic [7:0] VERSION_MIN = 8'h00,
    parameter logic [7:0] LINK_CAPS   = 8'h95
) (
    input  logic              clk,
    input  logic              rst,
    i2c_regmap_slave_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_sclSync;
    logic [1:0] r_sdaSync;
    logic       r_sclPrev;
    logic       r_sdaPrev;
    logic [7:0] r_swMeta;
    logic [7:0] r_swSync;
    logic [3:0] r_bitCnt;
    logic [7:0] r_shift;
    logic [7:0] r_txShift;
    logic [7:0] r_ptr;
    logic [7:0] r_scratch0;
    logic [7:0] r_scratch1;
    logic [7:0] r_ledOut;
    logic       r_sdaOe;
    logic       r_masterAck;

    logic       w_scl;
    logic       w_sda;
    logic       w_sclRise;
    logic       w_sclFall;
    logic       w_start;
    logic       w_stop;
    logic       w_byteDone;
    logic       w_rxState;
    logic       w_cntState;
    logic       w_nextSdaOe;
    logic       w_wrStb;
    logic       w_ptrLoad;
    logic       w_ptrInc;
    logic       w_loadTx;
    logic       w_shiftTx;
    logic [7:0] w_rdData;

    assign w_scl      = r_sclSync[1];
    assign w_sda      = r_sdaSync[1];
    assign w_sclRise  = w_scl & ~r_sclPrev;
    assign w_sclFall  = ~w_scl & r_sclPrev;
    assign w_start    = r_sclPrev & w_scl & r_sdaPrev & ~w_sda;
    assign w_stop     = r_sclPrev & w_scl & ~r_sdaPrev & w_sda;
    assign w_byteDone = w_sclFall & (r_bitCnt == 4'd8);
    assign w_rxState  = (r_state == ADDR) || (r_state == REG_ADDR) || (r_state == WR_DATA);
    assign w_cntState = w_rxState || (r_state == RD_DATA);

    assign bus.sda_o   = 1'b0;
    assign bus.sda_oe  = r_sdaOe;
    assign bus.led_out = r_ledOut;

    // Sync flops idle high so leaving reset on an idle bus produces no false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
            r_swMeta  <= 8'h00;
            r_swSync  <= 8'h00;
        end else begin
            r_sclSync <= {r_sclSync[0], bus.scl_i};
            r_sdaSync <= {r_sdaSync[0], bus.sda_i};
            r_sclPrev <= w_scl;
            r_sdaPrev <= w_sda;
            r_swMeta  <= bus.sw_in;
            r_swSync  <= r_swMeta;
        end
    end

    always_comb begin
        w_rdData = 8'h00;
        case (r_ptr)
            8'h00:   w_rdData = DEVICE_ID;
            8'h01:   w_rdData = VERSION_MAJ;
            8'h02:   w_rdData = VERSION_MIN;
            8'h03:   w_rdData = {7'b0, bus.spi_active};
            8'h04:   w_rdData = bus.spi_rx_byte;
            8'h05:   w_rdData = r_scratch0;
            8'h06:   w_rdData = r_scratch1;
            8'h10:   w_rdData = LINK_CAPS;
            8'h20:   w_rdData = r_ledOut;
            8'h22:   w_rdData = r_swSync;
            default: w_rdData = 8'h00;
        endcase
    end

    // Every sda_oe change is keyed to an SCL fall, so SDA never moves while SCL is high.
    always_comb begin
        w_nextState = r_state;
        w_nextSdaOe = r_sdaOe;
        w_wrStb     = 1'b0;
        w_ptrLoad   = 1'b0;
        w_ptrInc    = 1'b0;
        w_loadTx    = 1'b0;
        w_shiftTx   = 1'b0;
        if (w_start) begin
            w_nextState = ADDR;
            w_nextSdaOe = 1'b0;
        end else if (w_stop) begin
            w_nextState = IDLE;
            w_nextSdaOe = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_byteDone) begin
                        if (r_shift[7:1] == SLAVE_ADDR) begin
                            w_nextState = ADDR_ACK;
                            w_nextSdaOe = 1'b1;
                        end else begin
                            w_nextState = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_sclFall) begin
                        if (r_shift[0]) begin
                            w_nextState = RD_DATA;
                            w_loadTx    = 1'b1;
                            w_nextSdaOe = ~w_rdData[7];
                        end else begin
                            w_nextState = REG_ADDR;
                            w_nextSdaOe = 1'b0;
                        end
                    end
                end
                REG_ADDR: begin
                    if (w_byteDone) begin
                        w_nextState = REG_ACK;
                        w_ptrLoad   = 1'b1;
                        w_nextSdaOe = 1'b1;
                    end
                end
                REG_ACK, WR_ACK: begin
                    if (w_sclFall) begin
                        w_nextState = WR_DATA;
                        w_nextSdaOe = 1'b0;
                    end
                end
                WR_DATA: begin
                    if (w_byteDone) begin
                        w_nextState = WR_ACK;
                        w_wrStb     = 1'b1;
                        w_nextSdaOe = 1'b1;
`ifdef I2C_AUTOINC_EN
                        w_ptrInc    = 1'b1;
`endif
                    end
                end
                RD_DATA: begin
                    if (w_byteDone) begin
                        w_nextState = RD_ACK;
                        w_nextSdaOe = 1'b0;
                    end else if (w_sclFall) begin
                        w_shiftTx   = 1'b1;
                        w_nextSdaOe = ~r_txShift[6];
                    end
                end
                RD_ACK: begin
`ifdef I2C_AUTOINC_EN
                    if (w_sclRise) begin
                        w_ptrInc = 1'b1;
                    end
`endif
                    if (w_sclFall) begin
                        if (r_masterAck) begin
                            w_nextState = RD_DATA;
                            w_loadTx    = 1'b1;
                            w_nextSdaOe = ~w_rdData[7];
                        end else begin
                            w_nextState = WAIT_STOP;
                            w_nextSdaOe = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sdaOe <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_sdaOe <= w_nextSdaOe;
        end
    end

    // Register writes land here; led_out follows r_ledOut one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt    <= 4'd0;
            r_shift     <= 8'h00;
            r_txShift   <= 8'h00;
            r_ptr       <= 8'h00;
            r_scratch0  <= 8'h00;
            r_scratch1  <= 8'h00;
            r_ledOut    <= 8'h00;
            r_masterAck <= 1'b0;
        end else begin
            if (w_start || (w_nextState != r_state)) begin
                r_bitCnt <= 4'd0;
            end else if (w_sclRise && w_cntState && (r_bitCnt != 4'd8)) begin
                r_bitCnt <= r_bitCnt + 4'd1;
            end
            if (w_sclRise && w_rxState) begin
                r_shift <= {r_shift[6:0], w_sda};
            end
            if (w_sclRise && (r_state == RD_ACK)) begin
                r_masterAck <= ~w_sda;
            end
            if (w_loadTx) begin
                r_txShift <= w_rdData;
            end else if (w_shiftTx) begin
                r_txShift <= {r_txShift[6:0], 1'b0};
            end
            if (w_ptrLoad) begin
                r_ptr <= r_shift;
            end else if (w_ptrInc) begin
                r_ptr <= r_ptr + 8'd1;
            end
            if (w_wrStb) begin
                case (r_ptr)
                    8'h05:   r_scratch0 <= r_shift;
                    8'h06:   r_scratch1 <= r_shift;
                    8'h20:   r_ledOut   <= r_shift;
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_regmap_slave.sv
// Scoreboard bench for i2c_regmap_slave: an I2C master model issues register transactions,
// expected ACK levels and read bytes are queued, and a monitor compares each observation.
module tb_i2c_regmap_slave;
    localparam int Q = 100;

    typedef struct {
        string      name;
        logic [7:0] value;
    } expItem_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic mScl    = 1'b1;
    logic mSdaLow = 1'b0;

    expItem_t   expQ[$];
    int         passCount  = 0;
    int         checkCount = 0;
    logic       obsStrobe  = 1'b0;
    logic [7:0] obsData    = 8'h00;

    i2c_regmap_slave_if busIf ();

    // Open-drain bus: either side pulling low wins.
    assign busIf.scl_i = mScl;
    assign busIf.sda_i = ~(mSdaLow | busIf.sda_oe);

    i2c_regmap_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    always #5 clk = ~clk;

    task automatic pushExpected(input string name, input logic [7:0] value);
        expItem_t it;
        it.name  = name;
        it.value = value;
        expQ.push_back(it);
    endtask

    task automatic publish(input logic [7:0] value);
        obsData   = value;
        obsStrobe = ~obsStrobe;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Monitor: every observation pops one expectation.
    initial begin
        expItem_t item;
        forever begin
            @(obsStrobe);
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_obs: got 0x%02h, expected no observation", obsData);
            end else begin
                item = expQ.pop_front();
                checkOutput(item.name, obsData, item.value);
            end
        end
    end

    task automatic i2cStart();
        mSdaLow = 1'b0; #Q;
        mScl    = 1'b1; #Q;
        mSdaLow = 1'b1; #Q;
        mScl    = 1'b0; #Q;
    endtask

    task automatic i2cStop();
        mSdaLow = 1'b1; #Q;
        mScl    = 1'b1; #Q;
        mSdaLow = 1'b0; #Q;
    endtask

    task automatic writeBit(input logic b);
        mSdaLow = ~b; #Q;
        mScl    = 1'b1; #(2 * Q);
        mScl    = 1'b0; #Q;
    endtask

    task automatic readBit(output logic b);
        mSdaLow = 1'b0; #Q;
        mScl    = 1'b1; #Q;
        b       = busIf.sda_i; #Q;
        mScl    = 1'b0; #Q;
    endtask

    // expSda is the SDA level expected on the 9th clock: 0 = target ACK, 1 = no ACK.
    task automatic writeByte(input logic [7:0] d, input string name, input logic expSda);
        logic a;
        pushExpected(name, {7'b0, expSda});
        for (int i = 7; i >= 0; i--) begin
            writeBit(d[i]);
        end
        readBit(a);
        publish({7'b0, a});
    endtask

    task automatic readByte(input string name, input logic [7:0] expData, input logic masterAck);
        logic [7:0] d;
        logic       b;
        pushExpected(name, expData);
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        publish(d);
        writeBit(~masterAck);
    endtask

    // One register transaction: pointer write, then either a data write or Sr + single-byte read.
    task automatic applyStimulus(input logic isRead, input logic [7:0] regAddr,
                                 input logic [7:0] value, input string name);
        i2cStart();
        writeByte(8'hA0, "addr_w_ack", 1'b0);
        writeByte(regAddr, "reg_ack", 1'b0);
        if (isRead) begin
            i2cStart();
            writeByte(8'hA1, "addr_r_ack", 1'b0);
            readByte(name, value, 1'b0);
        end else begin
            writeByte(value, name, 1'b0);
        end
        i2cStop();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expItem_t item;
        busIf.sw_in       = 8'h00;
        busIf.spi_active  = 1'b0;
        busIf.spi_rx_byte = 8'h00;
        rst = 1'b1;
        #50;
        rst = 1'b0;
        #20;
        pushExpected("rst_led_out", 8'h00);
        publish(busIf.led_out);
        #10;
        pushExpected("rst_sda_oe", 8'h00);
        publish({7'b0, busIf.sda_oe});
        #(4 * Q);

        $display("[TB] identification registers");
        applyStimulus(1'b1, 8'h00, 8'hA7, "rd_device_id");
        applyStimulus(1'b1, 8'h01, 8'h01, "rd_version_maj");
        applyStimulus(1'b1, 8'h02, 8'h00, "rd_version_min");

        $display("[TB] scratch registers");
        applyStimulus(1'b0, 8'h05, 8'h55, "wr_scratch0_55");
        applyStimulus(1'b1, 8'h05, 8'h55, "rd_scratch0_55");
        applyStimulus(1'b0, 8'h05, 8'hAA, "wr_scratch0_aa");
        applyStimulus(1'b1, 8'h05, 8'hAA, "rd_scratch0_aa");
        applyStimulus(1'b0, 8'h06, 8'h12, "wr_scratch1");
        applyStimulus(1'b1, 8'h06, 8'h12, "rd_scratch1");

        // Read with no pointer write: the pointer persists from the previous transaction.
        i2cStart();
        writeByte(8'hA1, "addr_r_ack", 1'b0);
`ifdef I2C_AUTOINC_EN
        readByte("rd_persist_ptr", 8'h00, 1'b0);
`else
        readByte("rd_persist_ptr", 8'h12, 1'b0);
`endif
        i2cStop();

        applyStimulus(1'b1, 8'h10, 8'h95, "rd_link_caps");

        $display("[TB] LED and switch registers");
        applyStimulus(1'b0, 8'h20, 8'hF0, "wr_led");
        #100;
        pushExpected("led_out_pin", 8'hF0);
        publish(busIf.led_out);
        applyStimulus(1'b1, 8'h20, 8'hF0, "rd_led");
        busIf.sw_in = 8'h3C;
        #100;
        applyStimulus(1'b1, 8'h22, 8'h3C, "rd_sw_in");

        $display("[TB] SPI status, read-only and unmapped addresses");
        busIf.spi_active  = 1'b1;
        busIf.spi_rx_byte = 8'h5A;
        applyStimulus(1'b1, 8'h03, 8'h01, "rd_status");
        applyStimulus(1'b1, 8'h04, 8'h5A, "rd_spi_rx");
        applyStimulus(1'b0, 8'h00, 8'hFF, "wr_ro_id");
        applyStimulus(1'b1, 8'h00, 8'hA7, "rd_ro_id_kept");
        applyStimulus(1'b0, 8'h30, 8'h77, "wr_unmapped");
        applyStimulus(1'b1, 8'h30, 8'h00, "rd_unmapped");

        $display("[TB] foreign address");
        i2cStart();
        writeByte(8'hA2, "foreign_addr_nack", 1'b1);
        i2cStop();
        applyStimulus(1'b1, 8'h05, 8'hAA, "rd_after_foreign");

        $display("[TB] reset during address ACK");
        i2cStart();
        for (int i = 7; i >= 0; i--) begin
            writeBit(i == 7 || i == 5);
        end
        pushExpected("ack_driven", 8'h01);
        publish({7'b0, busIf.sda_oe});
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #10;
        pushExpected("rst_mid_sda_oe", 8'h00);
        publish({7'b0, busIf.sda_oe});
        #10;
        pushExpected("rst_mid_led_out", 8'h00);
        publish(busIf.led_out);
        #(2 * Q);
        applyStimulus(1'b1, 8'h05, 8'h00, "rd_scratch0_cleared");
        applyStimulus(1'b1, 8'h20, 8'h00, "rd_led_cleared");

        #(10 * Q);
        while (expQ.size() > 0) begin
            item = expQ.pop_front();
            checkCount++;
            $display("[TB] FAIL %s: no observation, expected 0x%02h", item.name, item.value);
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/i2c_regmap_slave.md
Name: i2c_regmap_slave

Overview:
- 7-bit-address I2C target (slave) with an integrated 8-bit register map; one block replaces the separate i2c_slave + register_file pair.
- Sits between the MCU's I2C pins (via external open-drain pad logic) and board I/O: LEDs, switches, SPI status.
- Supports register-pointer write, data write, and read via repeated START, up to 400 kHz SCL with clk ≥ 50 MHz (nominal 100 MHz).

Parameters:
SLAVE_ADDR, 7'h50, 7-bit bus address matched by the target
DEVICE_ID, 8'hA7, value returned at reg 0x00
VERSION_MAJ, 8'h01, value returned at reg 0x01
VERSION_MIN, 8'h00, value returned at reg 0x02
LINK_CAPS, 8'h95, value returned at reg 0x10

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
scl_i  in  1  SCL line, asynchronous
sda_i  in  1  SDA line as resolved on the bus, asynchronous
sda_o  out  1  SDA output value; held 0
sda_oe  out  1  1 = pull SDA low; 0 = release (pull-up yields 1)
led_out  out  8  LED drive, mirrors LED_OUT register
sw_in  in  8  switch inputs, asynchronous
spi_active  in  1  SPI link active status
spi_rx_byte  in  8  last byte received by the SPI block

Behaviour:
- Input sync: scl_i, sda_i and sw_in each pass through 2-FF synchronizers; edges are detected on the synchronized SCL/SDA.
- START / repeated START: SDA falls while SCL is high. The FSM goes to ADDR from any state and the bit counter clears.
- STOP: SDA rises while SCL is high. The FSM goes to IDLE from any state and sda_oe is released.
- Data rules: bits are sampled on the SCL rising edge, MSB first. sda_oe may change only in the clk cycle after a detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - ADDR: shift in 8 bits. If addr[7:1]==SLAVE_ADDR, go to ADDR_ACK and drive ACK (sda_oe=1) for the 9th clock. Otherwise go to WAIT_STOP with SDA never driven.
  - ADDR_ACK: if R/W=0, go to REG_ADDR. If R/W=1, latch the read data of the current pointer into the TX shifter and go to RD_DATA.
  - REG_ADDR: 8 bits load the register pointer; ACK; then go to WR_DATA.
  - WR_DATA: after 8 bits, write the byte to the register at the pointer (one-cycle internal write strobe); ACK; stay in WR_DATA for further bytes.
  - RD_DATA: drive sda_oe = ~tx_bit after each SCL fall for 8 bits, then release SDA for RD_ACK.
  - RD_ACK: master ACK (SDA=0) reloads the TX shifter from the pointer and returns to RD_DATA. Master NACK goes to WAIT_STOP.
- Register map (8-bit address; RO writes ignored; unmapped addresses read 0x00, writes dropped):
  - 0x00 DEVICE_ID (RO)
  - 0x01 VERSION_MAJ (RO)
  - 0x02 VERSION_MIN (RO)
  - 0x03 STATUS (RO): bit0 = spi_active, others 0
  - 0x04 SPI_RX (RO): spi_rx_byte
  - 0x05 SCRATCH0 (RW)
  - 0x06 SCRATCH1 (RW)
  - 0x10 LINK_CAPS (RO)
  - 0x20 LED_OUT (RW): drives led_out
  - 0x22 SW_IN (RO): synchronized sw_in
- Reset values: FSM IDLE, sda_oe=0, sda_o=0, pointer 0x00, SCRATCH0/1=0x00, LED_OUT=0x00, so led_out=0x00.
- led_out updates in the clk cycle after the internal write strobe.
- Pointer persists across transactions, including through a repeated START.
- Reset asserted mid-transfer: SDA released immediately, registers cleared, FSM IDLE. The bus is ignored until the next START.
- Simultaneous START and STOP detection cannot occur. A START detected in any state has priority over bit processing.

Optional Feature:
- Macro: I2C_AUTOINC_EN.
- Defined: the pointer increments, wrapping 0xFF to 0x00, after each WR_DATA byte commit and after each RD_ACK.
- Undefined: the pointer changes only in REG_ADDR. Multi-byte bursts reuse the same register.

Test Plan:
- Reset, then read reg 0x00 (write pointer, repeated START, read, NACK, STOP) -> 0xA7. Reg 0x01 -> 0x01, reg 0x02 -> 0x00.
- Write 0x55 to 0x05 then read it -> 0x55. Write 0xAA then read -> 0xAA. Write 0x12 to 0x06 then read -> 0x12.
- Read 0x10 -> 0x95.
- Write 0xF0 to 0x20 -> led_out=0xF0 within 100 ns after STOP; read 0x20 -> 0xF0.
- Set sw_in=0x3C, wait 100 ns, read 0x22 -> 0x3C.
- Address byte 0xA2 (addr 0x51, write) -> no ACK (SDA high on 9th clock); the next valid transaction still ACKs.
